hex_entry_stack: RTL

Parametrised hexadecimal entry register for the PDU front panel. It accumulates digits typed on the switches into a multi-digit value, with:
- internal rising-edge detection of the button inputs;
- digit-count tracking;
- a selectable overflow policy;
- a multi-level undo history.

It sits between the debounced button/switch inputs and the PDU command decoder, and drives the displayed operand.

---
 rtl/hex_entry_stack_pkg.sv | 15 +
 rtl/hex_entry_stack_undo.sv | 42 ++++
 rtl/hex_entry_stack.sv | 115 +++++++++++
 3 files changed

// File: rtl/hex_entry_stack_pkg.sv
// pdu_pkg: shared constants and command encoding for the PDU hex entry register
//   OVF_SHIFT / OVF_SAT : overflow policy selectors for hex_entry_stack
//   cmd_e               : single command selected per cycle after priority encoding
package pdu_pkg;
    localparam int OVF_SHIFT = 0;
    localparam int OVF_SAT   = 1;
    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_SET,
        CMD_CLR,
        CMD_ADD,
        CMD_DEL,
        CMD_UNDO
    } cmd_e;
endpackage

// File: rtl/hex_entry_stack_undo.sv
// undo_stack: circular LIFO history that overwrites its oldest entry when full
//   clk, rst    : clock, synchronous active-high reset (clears occupancy)
//   push, pop   : store wdata / drop newest entry (never both in one cycle)
//   wdata       : entry to store
//   rdata       : newest stored entry
//   empty       : no entries held
module undo_stack #(
    parameter int ENTRY_W = 36,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] wdata,
    output logic [ENTRY_W-1:0] rdata,
    output logic               empty
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0] wp, wp_nxt, wp_prv;
    logic [OW-1:0] occ;
    // Pointer wrap is explicit so non-power-of-two depths stay circular.
    assign wp_nxt = wp == PW'(DEPTH - 1) ? '0 : wp + PW'(1);
    assign wp_prv = wp == '0 ? PW'(DEPTH - 1) : wp - PW'(1);
    assign rdata  = mem[wp_prv];
    assign empty  = occ == '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            occ <= '0;
        end else if (push) begin
            mem[wp] <= wdata;
            wp      <= wp_nxt;
            occ     <= occ == OW'(DEPTH) ? occ : occ + OW'(1);
        end else if (pop) begin
            wp  <= wp_prv;
            occ <= occ - OW'(1);
        end
    end
endmodule

// File: rtl/hex_entry_stack.sv
// hex_entry_stack: front-panel hex digit entry register with edge-detected commands and undo
//   clk, rst                  : clock, synchronous active-high reset
//   din, hex                  : parallel load value, switch digit
//   set, clr, add, del, undo  : debounced command levels, act on rising edge
//   dout, count, full, empty  : current value and entered-digit count with status
//   changed, err              : one-cycle pulses for accepted / rejected commands
module hex_entry_stack
    import pdu_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int DIGIT_W    = 4,
    parameter int OVF_MODE   = OVF_SHIFT,
    parameter int UNDO_DEPTH = 4,
    localparam int W  = DIGITS * DIGIT_W,
    localparam int CW = $clog2(DIGITS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W-1:0]       din,
    input  logic [DIGIT_W-1:0] hex,
    input  logic               add,
    input  logic               del,
    input  logic               set,
    input  logic               clr,
    input  logic               undo,
    output logic [W-1:0]       dout,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               empty,
    output logic               changed,
    output logic               err
);
    logic [4:0] btn, prev, edg;
    cmd_e cmd;
    logic [W-1:0] nxt_dout;
    logic [CW-1:0] nxt_count, set_cnt;
    logic acc, rej, hist_empty;
    logic [W+CW-1:0] hist_rdata;
    assign btn = {set, clr, add, del, undo};
    assign edg = btn & ~prev;
    assign cmd = edg[4] ? CMD_SET :
                 edg[3] ? CMD_CLR :
                 edg[2] ? CMD_ADD :
                 edg[1] ? CMD_DEL :
                 edg[0] ? CMD_UNDO : CMD_NONE;
    // Digit count for a parallel load: position of the highest nonzero digit plus one.
    always_comb begin
        set_cnt = '0;
        for (int i = 0; i < DIGITS; i++)
            if (din[i*DIGIT_W +: DIGIT_W] != '0) set_cnt = CW'(i + 1);
    end
    always_comb begin
        nxt_dout  = dout;
        nxt_count = count;
        acc       = 1'b0;
        case (cmd)
            CMD_SET: begin
                nxt_dout  = din;
                nxt_count = set_cnt;
                acc       = 1'b1;
            end
            CMD_CLR: begin
                nxt_dout  = '0;
                nxt_count = '0;
                acc       = !empty;
            end
            CMD_ADD: begin
                nxt_dout  = (dout << DIGIT_W) | W'(hex);
                nxt_count = full ? count : count + CW'(1);
                acc       = !full || OVF_MODE == OVF_SHIFT;
            end
            CMD_DEL: begin
                nxt_dout  = dout >> DIGIT_W;
                nxt_count = count - CW'(1);
                acc       = !empty;
            end
            CMD_UNDO: begin
                {nxt_dout, nxt_count} = hist_rdata;
                acc                   = !hist_empty;
            end
            default: ;
        endcase
    end
    assign rej = cmd != CMD_NONE && !acc;
    undo_stack #(.ENTRY_W(W + CW), .DEPTH(UNDO_DEPTH)) u_hist (
        .clk   (clk),
        .rst   (rst),
        .push  (acc && cmd != CMD_UNDO),
        .pop   (acc && cmd == CMD_UNDO),
        .wdata ({dout, count}),
        .rdata (hist_rdata),
        .empty (hist_empty)
    );
    // Edge registers track the inputs during reset so a held button stays silent afterwards.
    always_ff @(posedge clk) begin
        prev <= btn;
        if (rst) begin
            dout    <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            changed <= 1'b0;
            err     <= 1'b0;
        end else begin
            changed <= acc;
            err     <= rej;
            if (acc) begin
                dout  <= nxt_dout;
                count <= nxt_count;
                full  <= nxt_count == CW'(DIGITS);
                empty <= nxt_count == '0;
            end
        end
    end
endmodule
